// File: rtl/uart_tx_engine_if.sv
// TX FIFO read port between the FIFO and the UART transmit engine.
// master = engine side (pops), slave = FIFO side (supplies data/empty).
interface uart_tx_engine_if;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_pop;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_pop
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_pop
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start / 5-8 data / optional parity / 1-2 stop.
// Optional stick parity is compiled in with `define UART_TX_STICK_PARITY_EN.
module uart_tx_engine #(
    parameter int OVS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              baud_pulse,
    input  logic [1:0]        wls,
    input  logic              stb,
    input  logic              pen,
    input  logic              eps,
    input  logic              sticky,
    input  logic              break_ctl,
    output logic              tx,
    output logic              busy,
    output logic              temt,
    uart_tx_engine_if.master  fifo
);

    localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    wls_q, wls_d;
    logic          stb_q, stb_d;
    logic          pen_q, pen_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;

    logic          load;
    logic          bit_end;
    logic [7:0]    data_mask;
    logic          par_bit;

    assign load    = (state_q == IDLE) && en && !fifo.fifo_empty;
    assign bit_end = baud_pulse && (tick_q == TW'(OVS - 1));

    // Parity is resolved once at the pop, from the masked word.
    always_comb begin
        data_mask = fifo.fifo_dout & (8'hFF >> (2'd3 - wls));
        par_bit   = eps ? (^data_mask) : ~(^data_mask);
`ifdef UART_TX_STICK_PARITY_EN
        if (pen && sticky) begin
            par_bit = ~eps;
        end
`endif
    end

`ifndef UART_TX_STICK_PARITY_EN
    logic unused_sticky;
    assign unused_sticky = sticky;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wls_q   <= '0;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wls_q   <= wls_d;
            stb_q   <= stb_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wls_d   = wls_q;
        stb_d   = stb_q;
        pen_d   = pen_q;
        par_d   = par_q;

        if (state_q == IDLE) begin
            tick_d = '0;
        end else if (baud_pulse) begin
            tick_d = bit_end ? '0 : tick_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    shift_d = fifo.fifo_dout;
                    wls_d   = wls;
                    stb_d   = stb;
                    pen_d   = pen;
                    par_d   = par_bit;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == ({1'b0, wls_q} + 3'd4)) begin
                        bit_d   = '0;
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == {2'b00, stb_q}) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is computed from the next state so the flop lines up with it.
    always_comb begin
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        if (break_ctl) begin
            tx_d = 1'b0;
        end
        fifo.fifo_pop = load;
        busy          = (state_q != IDLE);
        temt          = (state_q == IDLE) && fifo.fifo_empty;
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine (OVS=16, strobe every 2 clks).
// A FIFO model, a line monitor and a frame-level reference model.
module tb_uart_tx_engine;

    localparam int OVS = 16;
    localparam int MAXF = 128;
`ifdef UART_TX_STICK_PARITY_EN
    localparam bit STICK_BUILD = 1'b1;
`else
    localparam bit STICK_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       baud_pulse = 1'b0;
    logic [1:0] wls = 2'd3;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky = 1'b0;
    logic       break_ctl = 1'b0;
    logic       tx;
    logic       busy;
    logic       temt;

    uart_tx_engine_if u_if ();

    uart_tx_engine #(.OVS(OVS)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .baud_pulse (baud_pulse),
        .wls        (wls),
        .stb        (stb),
        .pen        (pen),
        .eps        (eps),
        .sticky     (sticky),
        .break_ctl  (break_ctl),
        .tx         (tx),
        .busy       (busy),
        .temt       (temt),
        .fifo       (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) baud_pulse <= ~baud_pulse;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: list of bit levels in transmit order.
    function automatic void build_frame(
        input  logic [7:0]  d,
        input  logic [1:0]  w,
        input  logic        s,
        input  logic        p,
        input  logic        e,
        input  logic        st,
        output logic [15:0] v,
        output int          n
    );
        int   nd;
        logic ones;
        nd = int'(w) + 5;
        v = '0;
        n = 1;
        ones = 1'b0;
        for (int i = 0; i < nd; i++) begin
            v[n] = d[i];
            ones = ones ^ d[i];
            n++;
        end
        if (p) begin
            if (st && STICK_BUILD) v[n] = ~e;
            else v[n] = e ? ones : ~ones;
            n++;
        end
        v[n] = 1'b1;
        n++;
        if (s) begin
            v[n] = 1'b1;
            n++;
        end
    endfunction

    // FIFO model plus pop recording (reacts like the FIFO flops).
    logic [7:0]  fifo_q[$];
    int          pop_cnt = 0;
    int          bad_pop = 0;
    logic [15:0] mdl_vec[MAXF];
    int          mdl_n[MAXF];

    always @(posedge clk) begin
        logic [7:0]  junk;
        logic [15:0] v;
        int          n;
        if (u_if.fifo_pop) begin
            if (fifo_q.size() == 0 || busy) bad_pop++;
            build_frame(u_if.fifo_dout, wls, stb, pen, eps, sticky, v, n);
            if (pop_cnt < MAXF) begin
                mdl_vec[pop_cnt] = v;
                mdl_n[pop_cnt]   = n;
            end
            pop_cnt++;
            if (fifo_q.size() > 0) junk = fifo_q.pop_front();
        end
        u_if.fifo_empty <= (fifo_q.size() == 0);
        u_if.fifo_dout  <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // Line monitor: sample tx at every strobe while busy.
    int          frame_cnt = 0;
    int          nsamp = 0;
    logic [15:0] cur_vec = '0;
    bit          cur_uni = 1'b1;
    int          got_len[MAXF];
    logic [15:0] got_vec[MAXF];
    bit          got_uni[MAXF];
    bit          prev_busy = 1'b0;
    int          idle_run = 1000;
    int          last_gap = 1000;

    always @(negedge clk) begin
        int b;
        if (prev_busy && !busy) begin
            if (frame_cnt < MAXF) begin
                got_len[frame_cnt] = nsamp;
                got_vec[frame_cnt] = cur_vec;
                got_uni[frame_cnt] = cur_uni;
            end
            frame_cnt++;
            nsamp    = 0;
            cur_vec  = '0;
            cur_uni  = 1'b1;
            idle_run = 1;
        end else if (!busy) begin
            idle_run++;
        end
        if (!prev_busy && busy) last_gap = idle_run;
        if (busy && baud_pulse) begin
            b = nsamp / OVS;
            if (b < 16) begin
                if (nsamp % OVS == 0) cur_vec[b] = tx;
                else if (cur_vec[b] != tx) cur_uni = 1'b0;
            end
            nsamp++;
        end
        prev_busy = busy;
    end

    task automatic chk(input bit ok, input string name,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int k;
        k = 0;
        while (frame_cnt < target && k < 4000) begin
            tick();
            k++;
        end
        if (frame_cnt < target) chk(1'b0, "frame_timeout", frame_cnt, target);
    endtask

    task automatic wait_samples(input int n);
        int k;
        k = 0;
        while (nsamp < n && k < 4000) begin
            tick();
            k++;
        end
        if (nsamp < n) chk(1'b0, "sample_timeout", nsamp, n);
    endtask

    task automatic check_model(input int i);
        bit ok;
        ok = (i < MAXF) && got_len[i] == mdl_n[i] * OVS &&
             got_vec[i] == mdl_vec[i] && got_uni[i];
        if (i < MAXF) chk(ok, $sformatf("model_frame%0d", i),
                          int'(got_vec[i]), int'(mdl_vec[i]));
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  wls;
        logic        stb;
        logic        pen;
        logic        eps;
        logic        sticky;
        int          nbits;
        logic [15:0] pat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int base;
        int p0;
        tbl[0] = '{8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10, 16'h02AA};
        tbl[1] = '{8'hFF, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0,  9, 16'h01FE};
        tbl[2] = '{8'h00, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 11, 16'h0600};
        tbl[3] = '{8'h00, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 11, 16'h0400};
        tbl[4] = '{8'hA1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 10, 16'h0342};
        tbl[5] = '{8'h3C, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0,  8, 16'h00F8};

        repeat (4) tick();
        chk(tx == 1'b1, "reset_tx", int'(tx), 1);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        chk(u_if.fifo_pop == 1'b0, "reset_pop", int'(u_if.fifo_pop), 0);
        chk(temt == 1'b1, "reset_temt", int'(temt), 1);
        rst = 1'b0;

        en = 1'b1;
        repeat (60) tick();
        chk(pop_cnt == 0, "empty_no_pop", pop_cnt, 0);
        chk(tx == 1'b1 && busy == 1'b0, "empty_idle", int'({tx, busy}), 2);
        chk(temt == 1'b1, "empty_temt", int'(temt), 1);

        en = 1'b0;
        fifo_q.push_back(tbl[0].data);
        repeat (100) tick();
        chk(pop_cnt == 0, "en0_no_pop", pop_cnt, 0);
        chk(busy == 1'b0 && temt == 1'b0, "en0_state",
            int'({busy, temt}), 0);

        for (int i = 0; i < 6; i++) begin
            wls    = tbl[i].wls;
            stb    = tbl[i].stb;
            pen    = tbl[i].pen;
            eps    = tbl[i].eps;
            sticky = tbl[i].sticky;
            base   = frame_cnt;
            if (i > 0) fifo_q.push_back(tbl[i].data);
            en = 1'b1;
            wait_frames(base + 1);
            tick();
            chk(got_len[base] == tbl[i].nbits * OVS,
                $sformatf("tbl%0d_strobes", i),
                got_len[base], tbl[i].nbits * OVS);
            chk(got_vec[base] == tbl[i].pat && got_uni[base],
                $sformatf("tbl%0d_bits", i),
                int'(got_vec[base]), int'(tbl[i].pat));
            chk(temt == 1'b1, $sformatf("tbl%0d_temt", i), int'(temt), 1);
        end

        wls = 2'd3;
        stb = 1'b0;
        pen = 1'b0;
        base = frame_cnt;
        p0 = pop_cnt;
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'h3C);
        wait_frames(base + 2);
        chk(pop_cnt - p0 == 2, "b2b_pops", pop_cnt - p0, 2);
        chk(last_gap <= 1, "b2b_gap", last_gap, 1);
        check_model(base);
        check_model(base + 1);

        base = frame_cnt;
        fifo_q.push_back(8'hFF);
        wait_samples(3 * OVS);
        break_ctl = 1'b1;
        tick();
        chk(tx == 1'b0, "break_on", int'(tx), 0);
        repeat (20) tick();
        chk(tx == 1'b0 && busy == 1'b1, "break_hold",
            int'({tx, busy}), 1);
        break_ctl = 1'b0;
        tick();
        chk(tx == 1'b1, "break_off", int'(tx), 1);
        wait_frames(base + 1);
        chk(got_len[base] == 10 * OVS, "break_len", got_len[base], 10 * OVS);

        fifo_q.push_back(8'h0F);
        wait_samples(3 * OVS);
        p0 = pop_cnt;
        rst = 1'b1;
        #1;
        chk(tx == 1'b1 && busy == 1'b0, "rst_mid_frame",
            int'({tx, busy}), 2);
        repeat (5) tick();
        rst = 1'b0;
        repeat (100) tick();
        chk(pop_cnt == p0, "rst_no_pop", pop_cnt, p0);
        chk(busy == 1'b0 && temt == 1'b1, "rst_after",
            int'({busy, temt}), 1);

        base = frame_cnt;
        for (int k = 0; k < 40000 && frame_cnt < base + 30; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                wls    = 2'($urandom_range(0, 3));
                stb    = 1'($urandom_range(0, 1));
                pen    = 1'($urandom_range(0, 1));
                eps    = 1'($urandom_range(0, 1));
                sticky = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 149) == 0) en = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < 2 && $urandom_range(0, 99) == 0)
                fifo_q.push_back(8'($urandom()));
            tick();
        end
        en = 1'b0;
        for (int k = 0; k < 4000 && busy; k++) tick();
        tick();
        chk(frame_cnt >= base + 30, "rand_frames", frame_cnt, base + 30);
        for (int i = base; i < frame_cnt; i++) check_model(i);
        chk(frame_cnt == pop_cnt, "frames_vs_pops", frame_cnt, pop_cnt);
        chk(bad_pop == 0, "illegal_pop", bad_pop, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter: OVS, default 16, number of baud_pulse ticks per serial bit; legal values 4..64.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  transmitter enable; gates new frame starts only.
REQ-005 baud_pulse  input  1  single-clk strobe at OVS x baud rate.
REQ-006 fifo_dout  input  8  head-of-FIFO data, valid whenever fifo_empty=0.
REQ-007 fifo_empty  input  1  TX FIFO empty flag.
REQ-008 fifo_pop  output  1  one-clk pop strobe to TX FIFO.
REQ-009 wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-010 stb  input  1  stop bits: 0=one, 1=two.
REQ-011 pen  input  1  parity enable.
REQ-012 eps  input  1  even parity select: 1=even, 0=odd.
REQ-013 sticky  input  1  stick parity (used only when UART_TX_STICK_PARITY_EN is defined).
REQ-014 break_ctl  input  1  force serial line low.
REQ-015 tx  output  1  serial output, idle high.
REQ-016 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-017 temt  output  1  transmitter empty: high when state=IDLE and fifo_empty=1.

Function
REQ-018 The block SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE with en=1 and fifo_empty=0, the block SHALL assert fifo_pop for exactly one clk, load fifo_dout and wls/stb/pen/eps/sticky into internal registers on the same edge, and enter START.
REQ-020 The block SHALL never assert fifo_pop while fifo_empty=1 or outside IDLE.
REQ-021 Configuration latched at the pop SHALL govern the whole frame; mid-frame changes to wls/stb/pen/eps/sticky SHALL take effect at the next frame.
REQ-022 Each bit SHALL last exactly OVS baud_pulse strobes, counted by a tick counter cleared on each state or bit change; the state advances on the clk of the OVS-th strobe.
REQ-023 START SHALL drive tx=0; DATA SHALL drive data LSB-first for 5/6/7/8 bits per wls; bits above the word length SHALL be ignored.
REQ-024 PARITY SHALL be entered only if pen=1: with eps=1 it drives the XOR of the data bits, with eps=0 the inverse of that XOR.
REQ-025 STOP SHALL drive tx=1 for OVS strobes (stb=0) or 2*OVS strobes (stb=1), then return to IDLE.
REQ-026 Back-to-back frames SHALL be separated by at most one clk beyond the stop bit(s).
REQ-027 break_ctl=1 SHALL force tx=0 combinationally-registered within one clk, in any state, without disturbing FSM progress or counters.
REQ-028 en=0 mid-frame SHALL NOT abort the current frame; it only blocks the next pop.
REQ-029 tx SHALL be a registered output free of glitches.

Reset
REQ-030 On rst=1, the block SHALL set state=IDLE, tx=1, fifo_pop=0, busy=0, clear all counters and the shift register, and set temt=fifo_empty; reset mid-frame SHALL abort the frame immediately without a pop.

Configuration
REQ-031 Macro UART_TX_STICK_PARITY_EN: when defined, pen=1 with sticky=1 SHALL transmit a parity bit equal to ~eps (eps=1 gives 0, eps=0 gives 1); when undefined, the sticky input SHALL be ignored and parity follows REQ-024.

Verification
REQ-032 OVS=16, 8N1, FIFO holds 0x55 -> one pop; tx shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each bit 16 strobes; 160 strobes total; temt=1 afterwards.
REQ-033 wls=00, pen=1, eps=1, stb=1, data 0xFF -> data bits 1,1,1,1,1, parity 1, stop held 32 strobes; bits 7:5 not transmitted.
REQ-034 FIFO preloaded with 0xA1, 0x3C -> two pops, two frames, with the gap between the stop bit and the second start bit at most one clk.
REQ-035 fifo_empty=1 with en=1 -> no pop, tx=1, busy=0, temt=1; en=0 with FIFO non-empty -> no pop.
REQ-036 break_ctl pulsed during DATA -> tx=0 for the pulse duration and the frame ends on schedule; rst asserted mid-DATA -> tx=1 and busy=0 immediately, no extra pop.
REQ-037 With UART_TX_STICK_PARITY_EN defined, pen=1, sticky=1, eps=0, data 0x00 -> parity bit 1; with the macro undefined, same stimulus -> parity bit 1 (odd parity of 0x00); with eps=1 -> 0 in both builds.
